// File: rtl/wb32_sram_slave.sv
// Wishbone B3 classic 32-bit RAM slave: byte-lane writes, fixed wait states, single-cycle ack.
// Optional write protection of the low PROTECT_WORDS words when WB_RAM_WPROT_EN is defined.
module wb32_sram_slave #(
    parameter int AW            = 9,
    parameter int WAIT_STATES   = 1,
    parameter int PROTECT_WORDS = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

`ifdef WB_RAM_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          prot_q, prot_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          req, enter_resp, commit;

    logic [31:0]   mem [2**AW];

    // Address bits outside the decoded word index alias onto the same RAM.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            prot_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            prot_q  <= prot_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req) begin
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (!wb_cyc_i)        state_d = S_IDLE;
                else if (cnt_q == 0)  state_d = S_RESP;
                else                  cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the sampling edge, so the
    // request fields are taken straight from the bus in IDLE.
    always_comb begin
        adr_d  = adr_q;
        we_d   = we_q;
        sel_d  = sel_q;
        wdat_d = wdat_q;
        prot_d = prot_q;
        if (state_q == S_IDLE && req) begin
            adr_d  = wb_adr_i[AW+1:2];
            we_d   = wb_we_i;
            sel_d  = wb_sel_i;
            wdat_d = wb_dat_i;
            prot_d = WPROT_EN && wb_we_i && (32'(wb_adr_i[AW+1:2]) < 32'(PROTECT_WORDS));
        end
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign commit     = enter_resp && we_d && !prot_d;

    always_comb begin
        rdat_d = rdat_q;
        if (enter_resp && !we_d) rdat_d = mem[adr_d];
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && commit) begin
            for (int i = 0; i < 4; i++)
                if (sel_d[i]) mem[adr_d][8*i +: 8] <= wdat_d[8*i +: 8];
        end
    end

    always_comb begin
        wb_ack_o = (state_q == S_RESP) && !prot_q;
        wb_err_o = (state_q == S_RESP) &&  prot_q;
        wb_dat_o = rdat_q;
    end

endmodule

// File: tb/tb_wb32_sram_slave.sv
// Randomized + directed bench for wb32_sram_slave against a transaction-level RAM model.
module tb_wb32_sram_slave;
  localparam int AW = 9;
  localparam int WS = 1;
  localparam int PW = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o, err_o;

  wb32_sram_slave #(.AW(AW), .WAIT_STATES(WS), .PROTECT_WORDS(PW)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack_o),
    .wb_err_o(err_o));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc_n = 0;
  logic rst_seen = 1'b1;
  bit chk_en = 1'b0;

  // Model: RAM contents (X = never fully written) and per-cycle expected responses.
  logic [31:0] mm [0:2**AW-1];
  bit          exp_ack_q [int];
  bit          exp_err_q [int];
  logic [31:0] exp_dat_q [int];
  bit          exp_unk_q [int];
  logic [31:0] cur_dat = '0;
  bit          cur_kn = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc_n, act, exp);
    end
  endtask

  // Transfer sampled at edge k is answered in the cycle after edge k+1+WS (right after k when WS=0).
  function automatic int lat();
    return (WS == 0) ? 0 : WS + 1;
  endfunction

  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    rst_seen <= rst;
  end

  always @(negedge clk) if (chk_en) begin
    if (rst_seen) begin cur_dat = '0; cur_kn = 1'b1; end
    else if (exp_dat_q.exists(cyc_n)) begin cur_dat = exp_dat_q[cyc_n]; cur_kn = 1'b1; end
    else if (exp_unk_q.exists(cyc_n)) cur_kn = 1'b0;
    chk("ack", {31'b0, ack_o}, {31'b0, exp_ack_q.exists(cyc_n) && !rst_seen});
    chk("err", {31'b0, err_o}, {31'b0, exp_err_q.exists(cyc_n) && !rst_seen});
    if (cur_kn) chk("dat", dat_o, cur_dat);
  end

  // Called #1 after a posedge; leaves the request asserted (back-to-back friendly).
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output int lat_o, output logic [31:0] rd, output logic er);
    int c, idx, ec, acyc;
    bit pr;
    c = cyc_n; idx = int'(a[AW+1:2]); ec = c + 1 + lat();
    adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    pr = 1'b0;
`ifdef WB_RAM_WPROT_EN
    pr = w && (idx < PW);
`endif
    if (pr) exp_err_q[ec] = 1'b1; else exp_ack_q[ec] = 1'b1;
    if (w && !pr)
      for (int i = 0; i < 4; i++) if (s[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
    if (!w) begin
      if ($isunknown(mm[idx])) exp_unk_q[ec] = 1'b1; else exp_dat_q[ec] = mm[idx];
    end
    acyc = -1; rd = 'x; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_o || err_o) begin acyc = cyc_n; rd = dat_o; er = err_o; break; end
    end
    if (acyc < 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: no ack/err for adr %h within 40 cycles", a);
    end
    lat_o = acyc - c - 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cyc = 1'b0; stb = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int l;
  logic [31:0] r;
  logic e;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_ack", {31'b0, ack_o}, 32'h0);
    idle(1);

    // Basic write/read, latency and width
    xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, l, r, e); idle(1);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, l, r, e);
    chk("t1_lat", l, 2);
    chk("t1_dat", r, 32'hDEADBEEF);
    idle(2);

    // Byte lanes and empty sel
    xfer(32'h20, 32'h11223344, 4'hF, 1'b1, l, r, e);
    xfer(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, l, r, e);
    xfer(32'h20, 32'h0, 4'h0, 1'b0, l, r, e);
    chk("t2_lanes", r, 32'h11BB33DD);
    xfer(32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, l, r, e);
    chk("t2_sel0_err", {31'b0, e}, 32'h0);
    xfer(32'h20, 32'h0, 4'hF, 1'b0, l, r, e);
    chk("t2_sel0_keep", r, 32'h11BB33DD);
    idle(1);

    // Aliasing of undecoded address bits
    xfer(32'h0000_0804, 32'h5A5A5A5A, 4'hF, 1'b1, l, r, e);
    xfer(32'h4, 32'h0, 4'hF, 1'b0, l, r, e);
    chk("t3_alias", r, 32'h5A5A5A5A);
    idle(1);

    // Abort by dropping cyc during WAIT
    xfer(32'h30, 32'h12345678, 4'hF, 1'b1, l, r, e);
    xfer(32'h34, 32'h0BADF00D, 4'hF, 1'b1, l, r, e);
    idle(1);
    adr = 32'h30; dat = 32'h1; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    idle(4);
    xfer(32'h30, 32'h0, 4'hF, 1'b0, l, r, e);
    chk("t4_abort_keep", r, 32'h12345678);
    idle(1);

    // Reset while waiting: no ack, read data cleared, write lost
    adr = 32'h34; dat = 32'hCAFE0000; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    chk("t4_rst_dat", dat_o, 32'h0);
    idle(3);
    xfer(32'h34, 32'h0, 4'hF, 1'b0, l, r, e);
    chk("t4_rst_keep", r, 32'h0BADF00D);
    idle(1);

    // Back-to-back reads
    for (int i = 0; i < 8; i++) xfer(32'h40 + 4*i, 32'hA0000000 + i, 4'hF, 1'b1, l, r, e);
    idle(1);
    begin
      int acks = 0;
      for (int i = 0; i < 8; i++) begin
        xfer(32'h40 + 4*i, 32'h0, 4'h0, 1'b0, l, r, e);
        if (l >= 0) acks++;
        chk("t5_b2b_dat", r, 32'hA0000000 + i);
      end
      chk("t5_acks", acks, 8);
    end
    idle(2);

    // Write protection
    xfer(32'h8, 32'hFF, 4'hF, 1'b1, l, r, e);
`ifdef WB_RAM_WPROT_EN
    chk("t6_prot_err", {31'b0, e}, 32'h1);
`else
    chk("t6_noprot_err", {31'b0, e}, 32'h0);
    xfer(32'h8, 32'h0, 4'hF, 1'b0, l, r, e);
    chk("t6_noprot_dat", r, 32'hFF);
`endif
    xfer(32'h10, 32'h77, 4'hF, 1'b1, l, r, e);
    chk("t6_unprot_err", {31'b0, e}, 32'h0);
    idle(1);

    // Random traffic over a 32-word window with aliased upper bits
    for (int i = 0; i < 32; i++) xfer(32'(4*i), $urandom, 4'hF, 1'b1, l, r, e);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 31));
      xfer(a, $urandom, 4'($urandom), 1'($urandom), l, r, e);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
